logic_unit_iter: RTL
====================

# logic_unit_iter

Parametrised, multi-cycle logic unit. Successor to the single-cycle combinational and/or/xor/not operators. Executes one of eight bitwise operations on WIDTH-bit operands, SLICE bits per cycle, under a valid/ready handshake, and presents a registered result with negative/zero/cout/overflow flags. It sits in the integer datapath beside the adder/shifter units and shares their flag convention. It lets wide datapaths reuse one narrow slice of logic.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE ≥ 1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  3  000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT x, 111 PASS x.
- x, y  in  WIDTH  operands; y ignored for NOT/PASS.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- r  out  WIDTH  result register.
- negative, zero, cout, overflow  out  1 each  flags.
- parity  out  1  XOR-reduction of r; present only with LOGIC_PARITY_EN.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: slice counter cnt runs 0..NSLICE-1.
  - DONE: out_valid=1.
- IDLE→BUSY on in_valid&&in_ready. x, y and op are latched into internal registers; cnt←0; zero accumulator←1.
- BUSY, each cycle:
  - r[cnt*SLICE +: SLICE] ← op applied to the latched slice.
  - The zero accumulator is ANDed with ~|slice result.
  - cnt increments. On cnt==NSLICE-1 the next state is DONE.
  - With NSLICE=1, BUSY lasts exactly one cycle.
- DONE: r and the flags are held stable. On out_ready the next state is IDLE. out_valid stays high until out_ready.
- Flags (all registered, updated on the final slice):
  - negative = r[WIDTH-1].
  - zero = accumulated zero.
  - cout = 0 and overflow = 0, always.
- Inputs change freely after acceptance; only latched copies are used.
- r holds partial results during BUSY; consumers must qualify r with out_valid.
- Reset, at any time including mid-BUSY:
  - state→IDLE, cnt→0.
  - r, flags, parity → 0; out_valid→0.
  - in_ready is forced to 0 while rst is high, and rises in the first cycle after release.

## Timing
- Accept edge at cycle 0; out_valid rises after edge NSLICE (latency NSLICE cycles).
- DONE→IDLE takes one cycle after the out_ready edge. There is no accept in the DONE cycle, so peak throughput is one op per NSLICE+2 cycles.
- in_valid while not IDLE is ignored; the requester must hold the request until in_ready.
- out_valid and in_ready are never high together.

## Configuration
- LOGIC_PARITY_EN defined:
  - parity port exists.
  - A parity accumulator XORs ^slice each BUSY cycle and is registered with the other flags.
  - Reset value 0; held during DONE.
- Undefined: no parity port and no accumulator; all other behaviour is identical.

## Structure
- Package logic_pkg:
  - logic_op_t, a 3-bit enum with the encodings above.
  - logic_state_t: IDLE/BUSY/DONE.
- Sub-module logic_slice: combinational, parameter SLICE, inputs a/b/op, output SLICE-bit result. It is instanced once, and is reusable by the single-cycle operators.
- The counter width is $clog2(NSLICE), minimum 1 bit.

## Test plan (WIDTH=32, SLICE=8)
- AND: x=0xFF00FF00, y=0x0F0F0F0F → r=0x0F000F00, zero=0, negative=0, out_valid exactly 4 cycles after accept.
- NOR: x=0, y=0 → r=0xFFFFFFFF, negative=1, zero=0, cout=overflow=0.
- XOR: x=y=0xDEADBEEF → r=0, zero=1. Then XNOR on the same inputs → r=0xFFFFFFFF, zero=0.
- Backpressure: out_ready low 5 cycles after out_valid → r and flags stable, in_ready=0, in_valid pulses ignored. out_ready=1 → in_ready=1 next cycle.
- Reset mid-op: assert rst during cnt=2 of an OR → out_valid=0 and r=0 immediately. After release, NOT x=0x00000001 → r=0xFFFFFFFE, negative=1.
- LOGIC_PARITY_EN: PASS x=0x80000001 → parity=0. PASS x=0x00000007 → parity=1.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared types for the iterative logic unit: operation encodings and control states.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NAND = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_PASS = 3'b111
  } logic_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } logic_state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operator; shared by the iterative unit and single-cycle operators.
module logic_slice
  import logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic_op_t        op,
  output logic [SLICE-1:0] res
);

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_NAND: res = ~(a & b);
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_PASS: res = a;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_iter.sv
// Multi-cycle bitwise logic unit processing SLICE bits per cycle under valid/ready handshakes.
// Optional parity output and accumulator are enabled by defining LOGIC_PARITY_EN.
module logic_unit_iter
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             negative,
  output logic             zero,
  output logic             cout,
  output logic             overflow
`ifdef LOGIC_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  logic_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, r_q, r_d;
  logic_op_t        op_q, op_d;
  logic             zacc_q, zacc_d;
  logic             neg_q, neg_d, zero_q, zero_d;
  logic [SLICE-1:0] a_sl, b_sl, slice_res;
`ifdef LOGIC_PARITY_EN
  logic             pacc_q, pacc_d, parity_q, parity_d;
`endif

  assign a_sl = x_q[cnt_q*SLICE +: SLICE];
  assign b_sl = y_q[cnt_q*SLICE +: SLICE];

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .op  (op_q),
    .res (slice_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    r_d     = r_q;
    zacc_d  = zacc_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
`ifdef LOGIC_PARITY_EN
    pacc_d   = pacc_q;
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          op_d    = logic_op_t'(op);
          cnt_d   = '0;
          zacc_d  = 1'b1;
`ifdef LOGIC_PARITY_EN
          pacc_d  = 1'b0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        r_d[cnt_q*SLICE +: SLICE] = slice_res;
        zacc_d = zacc_q & ~(|slice_res);
`ifdef LOGIC_PARITY_EN
        pacc_d = pacc_q ^ (^slice_res);
`endif
        // Flags are committed together with the top slice, so they never reflect partial results.
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          cnt_d   = '0;
          neg_d   = r_d[WIDTH-1];
          zero_d  = zacc_d;
`ifdef LOGIC_PARITY_EN
          parity_d = pacc_d;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= OP_AND;
      r_q     <= '0;
      zacc_q  <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef LOGIC_PARITY_EN
      pacc_q   <= 1'b0;
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      r_q     <= r_d;
      zacc_q  <= zacc_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
`ifdef LOGIC_PARITY_EN
      pacc_q   <= pacc_d;
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign r         = r_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign cout      = 1'b0;
  assign overflow  = 1'b0;
`ifdef LOGIC_PARITY_EN
  assign parity    = parity_q;
`endif

endmodule
